// File: rtl/k12a_sequencer_regs_pkg.sv
// k12a_sequencer_regs_pkg: shared K12A sequencer types, encodings and constants
package k12a_sequencer_regs_pkg;

    typedef enum logic [2:0] {
        STATE_FETCH1 = 3'd0,
        STATE_FETCH2 = 3'd1,
        STATE_FETCH3 = 3'd2,
        STATE_EXEC   = 3'd3,
        STATE_HALT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SKIP_SEL_0                  = 2'd0,
        SKIP_SEL_CONDITION          = 2'd1,
        SKIP_SEL_CONDITION_INVERTED = 2'd2
    } skip_sel_t;

    localparam int K12A_WAKE_SYNC_STAGES_MIN = 2;

    // Unlisted encodings fall back to "no skip".
    function automatic logic skip_value(skip_sel_t sel, logic cond);
        return sel == SKIP_SEL_CONDITION          ? cond :
               sel == SKIP_SEL_CONDITION_INVERTED ? ~cond : 1'b0;
    endfunction

endpackage

// File: rtl/k12a_sync_edge.sv
// k12a_sync_edge: N-flop synchroniser with rising-edge detect on the synchronised output
module k12a_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic rise
);
    logic [STAGES-1:0] sync;
    logic              prev;

    // Shift the async input through the chain and remember the last synchronised value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= (sync << 1) | STAGES'(d);
            prev <= sync[STAGES-1];
        end
    end

    assign rise = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/k12a_sequencer_regs.sv
// k12a_sequencer_regs: state, instruction, skip, wake and retire-count registers around the K12A FSM
module k12a_sequencer_regs
    import k12a_sequencer_regs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   run_enable,
    input  state_t                 next_state,
    input  logic                   inst_high_store,
    input  logic                   inst_low_store,
    input  logic [7:0]             data_bus,
    input  skip_sel_t              skip_sel,
    input  logic                   skip_store,
    input  logic                   alu_condition,
    input  logic                   wake_request,
    output state_t                 state,
    output logic [15:0]            inst,
    output logic                   skip,
    output logic                   wake,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] inst_count
);
    if (SYNC_STAGES < K12A_WAKE_SYNC_STAGES_MIN) begin : g_bad_sync_stages
        $error("k12a_sequencer_regs: SYNC_STAGES must be at least 2");
    end

    logic wake_rise;
    logic wake_set;
    logic wake_clr;

    k12a_sync_edge #(.STAGES(SYNC_STAGES)) u_wake_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (wake_request),
        .rise    (wake_rise)
    );

    assign halted   = state == STATE_HALT;
    assign wake_set = wake_rise & halted;
    assign wake_clr = halted & run_enable & (next_state != STATE_HALT);

    // Architectural registers advance only while the core is running.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= STATE_FETCH1;
            inst       <= 16'h0000;
            skip       <= 1'b0;
            inst_count <= '0;
        end else if (run_enable) begin
            state <= next_state;
            if (inst_high_store)
                inst[15:8] <= data_bus;
            if (inst_low_store)
                inst[7:0] <= data_bus;
            if (skip_store)
                skip <= skip_value(skip_sel, alu_condition);
            if (state == STATE_EXEC)
                inst_count <= inst_count + COUNT_WIDTH'(1);
        end
    end

    // Wake latch runs through stalls; leaving HALT consumes it and beats a coincident edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            wake <= 1'b0;
        else
            wake <= wake_clr ? 1'b0 : (wake | wake_set);
    end

endmodule

// File: tb/tb_k12a_sequencer_regs.sv
// tb_k12a_sequencer_regs: directed scoreboard bench for the K12A sequencer registers
module tb_k12a_sequencer_regs;
    import k12a_sequencer_regs_pkg::*;

    localparam int CW = 4;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           run_enable = 1'b1;
    state_t         next_state = STATE_FETCH1;
    logic           inst_high_store = 1'b0;
    logic           inst_low_store = 1'b0;
    logic [7:0]     data_bus = 8'h00;
    skip_sel_t      skip_sel = SKIP_SEL_0;
    logic           skip_store = 1'b0;
    logic           alu_condition = 1'b0;
    logic           wake_request = 1'b0;
    state_t         state;
    logic [15:0]    inst;
    logic           skip;
    logic           wake;
    logic           halted;
    logic [CW-1:0]  inst_count;

    always #5 clock = ~clock;

    k12a_sequencer_regs #(.SYNC_STAGES(2), .COUNT_WIDTH(CW)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .run_enable      (run_enable),
        .next_state      (next_state),
        .inst_high_store (inst_high_store),
        .inst_low_store  (inst_low_store),
        .data_bus        (data_bus),
        .skip_sel        (skip_sel),
        .skip_store      (skip_store),
        .alu_condition   (alu_condition),
        .wake_request    (wake_request),
        .state           (state),
        .inst            (inst),
        .skip            (skip),
        .wake            (wake),
        .halted          (halted),
        .inst_count      (inst_count)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t          sb[$];
    int            compared = 0;
    int            mismatched = 0;
    state_t        m_state = STATE_FETCH1;
    logic [CW-1:0] m_cnt = '0;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            0:       return 32'(state);
            1:       return 32'(inst);
            2:       return 32'(skip);
            3:       return 32'(wake);
            4:       return 32'(halted);
            default: return 32'(inst_count);
        endcase
    endfunction

    task automatic push_exp(string tag, int sel, logic [31:0] v);
        sb.push_back('{tag, sel, v});
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            assert (observe(e.sel) === e.val)
            else begin
                mismatched++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, observe(e.sel), e.val);
            end
        end
    endtask

    // One clock: model state/count, queue expectations, then compare after the edge.
    task automatic cyc(string tag);
        if (run_enable) begin
            if (m_state == STATE_EXEC)
                m_cnt = m_cnt + 1'b1;
            m_state = next_state;
        end
        push_exp({tag, ".state"}, 0, 32'(m_state));
        push_exp({tag, ".halted"}, 4, 32'(m_state == STATE_HALT));
        push_exp({tag, ".count"}, 5, 32'(m_cnt));
        @(posedge clock);
        #1;
        drain();
    endtask

    task automatic rst_check(string tag);
        m_state = STATE_FETCH1;
        m_cnt   = '0;
        push_exp({tag, ".state"}, 0, 32'(STATE_FETCH1));
        push_exp({tag, ".inst"}, 1, 32'h0);
        push_exp({tag, ".skip"}, 2, 32'h0);
        push_exp({tag, ".wake"}, 3, 32'h0);
        push_exp({tag, ".halted"}, 4, 32'h0);
        push_exp({tag, ".count"}, 5, 32'h0);
        drain();
    endtask

    initial begin
        #12;
        rst_check("por");
        @(negedge clock);
        reset_n = 1'b1;

        next_state = STATE_FETCH2; data_bus = 8'h3C; inst_high_store = 1'b1;
        push_exp("fetch_hi", 1, 32'h3C00); cyc("fetch1");
        next_state = STATE_FETCH3; data_bus = 8'h81; inst_high_store = 1'b0; inst_low_store = 1'b1;
        push_exp("fetch_lo", 1, 32'h3C81); cyc("fetch2");
        inst_low_store = 1'b0; next_state = STATE_EXEC;
        push_exp("fetch_hold", 1, 32'h3C81); cyc("fetch3");
        next_state = STATE_FETCH1; cyc("exec");

        inst_high_store = 1'b1; inst_low_store = 1'b1; data_bus = 8'h5A;
        push_exp("both_halves", 1, 32'h5A5A); cyc("both");
        inst_high_store = 1'b0; inst_low_store = 1'b0;

        skip_store = 1'b1; skip_sel = SKIP_SEL_CONDITION; alu_condition = 1'b1;
        push_exp("skip_cond", 2, 32'h1); cyc("skip_cond");
        skip_sel = SKIP_SEL_CONDITION_INVERTED;
        push_exp("skip_inv", 2, 32'h0); cyc("skip_inv");
        skip_sel = SKIP_SEL_CONDITION;
        push_exp("skip_cond2", 2, 32'h1); cyc("skip_cond2");
        skip_store = 1'b0; skip_sel = SKIP_SEL_0; alu_condition = 1'b0;
        push_exp("skip_hold", 2, 32'h1); cyc("skip_hold");
        skip_store = 1'b1; skip_sel = skip_sel_t'(2'd3); alu_condition = 1'b1;
        push_exp("skip_other", 2, 32'h0); cyc("skip_other");
        skip_sel = SKIP_SEL_CONDITION;
        push_exp("skip_cond3", 2, 32'h1); cyc("skip_cond3");
        skip_sel = SKIP_SEL_0;
        push_exp("skip_zero", 2, 32'h0); cyc("skip_zero");
        skip_store = 1'b0;

        next_state = STATE_HALT;
        push_exp("halt_enter", 3, 32'h0); cyc("halt_enter");
        wake_request = 1'b1;
        push_exp("wake_lat1", 3, 32'h0); cyc("wake_lat1");
        push_exp("wake_lat2", 3, 32'h0); cyc("wake_lat2");
        push_exp("wake_lat3", 3, 32'h1); cyc("wake_lat3");
        push_exp("wake_hold", 3, 32'h1); cyc("wake_hold");
        next_state = STATE_FETCH1;
        push_exp("wake_clear", 3, 32'h0); cyc("wake_clear");
        next_state = STATE_HALT;
        for (int i = 0; i < 5; i++) begin
            push_exp("wake_no_rearm", 3, 32'h0); cyc("wake_no_rearm");
        end
        wake_request = 1'b0;
        for (int i = 0; i < 3; i++) cyc("settle1");

        next_state = STATE_EXEC; cyc("to_exec");
        wake_request = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_exp("stale_edge", 3, 32'h0); cyc("stale_edge");
        end
        next_state = STATE_HALT;
        for (int i = 0; i < 4; i++) begin
            push_exp("stale_drop", 3, 32'h0); cyc("stale_drop");
        end
        wake_request = 1'b0;
        for (int i = 0; i < 3; i++) cyc("settle2");

        next_state = STATE_EXEC; cyc("stall_enter");
        run_enable = 1'b0; next_state = STATE_FETCH1;
        inst_high_store = 1'b1; inst_low_store = 1'b1; data_bus = 8'hFF;
        skip_store = 1'b1; skip_sel = SKIP_SEL_CONDITION; alu_condition = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_exp("stall_inst", 1, 32'h5A5A);
            push_exp("stall_skip", 2, 32'h0);
            cyc("stall");
        end
        run_enable = 1'b1; inst_high_store = 1'b0; inst_low_store = 1'b0; skip_store = 1'b0;
        next_state = STATE_HALT; cyc("stall_halt");
        run_enable = 1'b0; next_state = STATE_FETCH1; wake_request = 1'b1;
        push_exp("stall_wake1", 3, 32'h0); cyc("stall_wake1");
        push_exp("stall_wake2", 3, 32'h0); cyc("stall_wake2");
        push_exp("stall_wake3", 3, 32'h1); cyc("stall_wake3");
        push_exp("stall_wake_hold", 3, 32'h1); cyc("stall_wake_hold");
        run_enable = 1'b1;
        push_exp("stall_wake_clear", 3, 32'h0); cyc("stall_wake_clear");
        wake_request = 1'b0;

        reset_n = 1'b0;
        #1;
        rst_check("rst_pre_wrap");
        @(negedge clock);
        reset_n = 1'b1;
        next_state = STATE_EXEC; cyc("wrap_enter");
        for (int i = 0; i < 17; i++) cyc("wrap");
        push_exp("wrap_result", 5, 32'h1);
        drain();

        inst_high_store = 1'b1; data_bus = 8'hAB; cyc("mid_hi");
        inst_high_store = 1'b0; inst_low_store = 1'b1; data_bus = 8'hCD; cyc("mid_lo");
        inst_low_store = 1'b0; skip_store = 1'b1; skip_sel = SKIP_SEL_CONDITION; alu_condition = 1'b1;
        cyc("mid_skip");
        skip_store = 1'b0; cyc("mid_idle");
        push_exp("mid_inst", 1, 32'hABCD);
        push_exp("mid_skip", 2, 32'h1);
        push_exp("mid_count", 5, 32'h5);
        push_exp("mid_state", 0, 32'(STATE_EXEC));
        drain();
        #2;
        reset_n = 1'b0;
        #1;
        rst_check("rst_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/k12a_sequencer_regs.md
Name: k12a_sequencer_regs

Overview:
Sequential state holder that sits directly upstream of the K12A control FSM. It registers the FSM's next_state, assembles the 16-bit instruction from two byte fetches, and holds the skip flag. It also synchronises the external wake request and generates the FSM's wake input, plus a retired-instruction counter for debug. The FSM is purely combinational; this block closes its loop.

Parameters:
SYNC_STAGES, 2, number of flops in the wake_request synchroniser (minimum 2).
COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
run_enable  input  1  high = registers advance; low = debug stall, architectural registers hold.
next_state  input  state_t  next state from the FSM.
inst_high_store  input  1  capture data_bus into inst[15:8].
inst_low_store  input  1  capture data_bus into inst[7:0].
data_bus  input  8  shared data bus.
skip_sel  input  skip_sel_t  skip source: SKIP_SEL_0, SKIP_SEL_CONDITION, SKIP_SEL_CONDITION_INVERTED.
skip_store  input  1  load the skip register.
alu_condition  input  1  ALU condition result for the current cycle.
wake_request  input  1  asynchronous external wake line, active-high.
state  output  state_t  current sequencer state, to the FSM.
inst  output  16  current instruction, to the FSM and datapath.
skip  output  1  skip flag, to the FSM.
wake  output  1  latched wake, to the FSM.
halted  output  1  high while state == STATE_HALT.
inst_count  output  COUNT_WIDTH  number of retired instructions.

Behaviour:
- Reset (async assert, sync-release assumed upstream): state=STATE_FETCH1, inst=16'h0000, skip=0, wake=0, all sync flops=0, edge-detect flop=0, inst_count=0. halted follows state, so it is 0.
- All registers below update only when run_enable=1. The exceptions are the synchroniser, the edge-detect flop and the wake latch, which run every cycle.
- State: state <= next_state. No illegal-state recovery is needed because state_t is fully decoded by the FSM.
- Instruction:
  - inst_high_store=1: inst[15:8] <= data_bus.
  - inst_low_store=1: inst[7:0] <= data_bus.
  - Both high in the same cycle: both halves load the same byte.
  - Neither high: inst holds.
  - Latency 1 cycle: the byte fetched in FETCH1 is visible on inst[15:8] in FETCH2.
- Skip, when skip_store=1:
  - SKIP_SEL_0 -> skip <= 0.
  - SKIP_SEL_CONDITION -> skip <= alu_condition.
  - SKIP_SEL_CONDITION_INVERTED -> skip <= ~alu_condition.
  - Any other encoding -> skip <= 0.
- Wake:
  - wake_request passes through a SYNC_STAGES flop chain.
  - A rising edge is detected as sync_out=1 with the previous sync_out=0.
  - The wake latch sets on a detected edge only while state==STATE_HALT.
  - The wake latch clears on the first cycle where state==STATE_HALT, run_enable=1 and next_state!=STATE_HALT.
  - Edges seen outside HALT are dropped, so a stale request does not cancel a later halt.
  - Set and clear in the same cycle: clear wins, and the edge is consumed.
  - A request held high continuously produces a single wake only.
  - Latency: edge on wake_request -> wake=1 after SYNC_STAGES+1 clocks (3 with the default).
- halted = (state==STATE_HALT), combinational from the state register.
- inst_count:
  - Increments by 1 on each cycle with run_enable=1 and state==STATE_EXEC.
  - Wraps from all-ones to 0 with no flag.
  - A skipped instruction still passes through EXEC and counts.
- Reset mid-operation: all registers return to reset values immediately; the next instruction fetch starts at FETCH1.

Decomposition:
- Use state_t, skip_sel_t and their encodings from the shared k12a package include; do not redefine them locally.
- Add a package constant K12A_WAKE_SYNC_STAGES_MIN = 2 and check SYNC_STAGES against it at elaboration.
- One natural sub-module: k12a_sync_edge, a parameterised N-flop synchroniser plus rising-edge detector with async active-low reset. It is reusable for future IO inputs.

Test Plan:
- Reset: assert reset_n=0 mid-EXEC with inst=16'hABCD, skip=1, inst_count=5 -> immediately state=FETCH1, inst=0, skip=0, inst_count=0, wake=0.
- Fetch: data_bus=8'h3C with inst_high_store, then 8'h81 with inst_low_store -> inst=16'h3C81 one cycle after each store; state follows next_state FETCH1->FETCH2->FETCH3->EXEC.
- Skip: skip_store with CONDITION/alu_condition=1 -> skip=1; INVERTED/alu_condition=1 -> skip=0; SKIP_SEL_0 -> skip=0; skip_store=0 -> skip holds.
- Wake: enter HALT, raise wake_request -> wake=1 exactly 3 clocks later; drive next_state=FETCH1 -> wake=0 the next cycle; wake_request held high yields no second wake. An edge while in EXEC followed by HALT -> wake stays 0.
- Stall: run_enable=0 for 4 cycles during EXEC with next_state=FETCH1 -> state, inst, skip and inst_count frozen; a wake edge during the stall in HALT is still latched.
- Counter wrap: COUNT_WIDTH=4, run 17 EXEC cycles -> inst_count=1.
